seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the tick counter and consumes its one-cycle `ready` pulse as a scan-rate strobe on `tick`. It displays a 16-bit hex value with per-digit decimal points and enables, and inserts a blanking gap between digits to suppress ghosting. The displayed value is latched once per frame, so a frame never mixes two values.

## Interface
- `SHOW_TICKS`, 4: ticks a digit is driven per scan slot; legal range 1..255.
- `BLANK_TICKS`, 1: ticks all anodes are off between slots; legal range 1..255.
- `clk` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-high.
- `tick` input 1: scan strobe from the upstream counter. Each `clk` cycle with `tick`=1 counts as one tick.
- `value` input 16: hex digits; digit d = `value[4d+3:4d]`, where digit 0 is the rightmost.
- `dp_in` input 4: bit d=1 lights the decimal point of digit d.
- `digit_en` input 4: bit d=0 blanks digit d entirely.
- `an` output 4: anodes, active-low; `an[d]` selects digit d.
- `seg` output 7: segments, active-low, bit order `seg[6:0]` = g,f,e,d,c,b,a.
- `dp` output 1: decimal point, active-low.
- `frame_done` output 1: one-cycle pulse when a full 4-digit frame has completed.

## Operation
- **State.**
  - FSM with states SHOW and BLANK.
  - 2-bit digit index `d`.
  - 8-bit slot counter.
  - Shadow registers for value, dp_in and digit_en (24 bits).
  - A `first` flag.
- **Reset values.**
  - Outputs: `an`=4'hF, `seg`=7'h7F, `dp`=1, `frame_done`=0.
  - Internal: state=BLANK, `d`=3, slot counter=0, shadows=0, `first`=1.
- **Ticks.** Counters advance only on cycles with `tick`=1. On cycles with `tick`=0 all state and outputs hold.
- **SHOW state.** On a tick, if counter == SHOW_TICKS-1, go to BLANK and clear the counter; otherwise increment the counter.
- **BLANK state.** On a tick, if counter == BLANK_TICKS-1:
  - go to SHOW, clear the counter, set `d` ← `d`+1 (mod 4);
  - otherwise increment the counter.
- **Frame wrap (`d` 3→0 on BLANK→SHOW).**
  - Latch `value`, `dp_in` and `digit_en` into the shadows on that same edge.
  - If `first`=0, assert `frame_done` on that edge; otherwise only clear `first`.
  - The first wrap after reset therefore latches inputs but does not pulse `frame_done`.
- **Outputs** are registered and update on the same edge as the state change.
  - SHOW with `shadow_en[d]`=1: `an`=~(4'b0001<<d), `seg`=decode(shadow nibble d), `dp`=~`shadow_dp[d]`.
  - SHOW with `shadow_en[d]`=0: `an`=4'hF, `seg`=7'h7F, `dp`=1.
  - BLANK: `an`=4'hF, `seg`=7'h7F, `dp`=1.
- **Decode** (active-low gfedcba) for 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- **Input changes** on `value`, `dp_in` or `digit_en` between wraps have no visible effect until the next wrap.
- **`frame_done` width.** It is high for exactly one `clk` cycle, never longer, regardless of `tick` pattern.

## Timing
- **Slot length.** One slot = SHOW_TICKS + BLANK_TICKS ticks. One frame = 4×(SHOW_TICKS+BLANK_TICKS) ticks.
- **First output after reset release.** The first digit-0 output appears on the BLANK_TICKS-th tick after reset deasserts, on the edge that samples that tick.
- **Output latency.** Outputs change on the clock edge that samples the qualifying tick. There is no additional latency.
- **Value latency.** From a `value` change to its display is at most one frame plus one slot.
- **Reset precedence.** `reset` overrides `tick`. Reset asserted mid-SHOW or mid-BLANK returns all state and outputs to reset values on the next edge. The scan then restarts with a fresh latch at digit 0.
- **Continuous tick.** `tick` held at 1 is legal; the block then advances every cycle.

## Test plan
- **Reset.** Assert `reset` 3 cycles with `tick`=1 -> `an`=F, `seg`=7F, `dp`=1, `frame_done`=0 throughout, and on the cycle after release while no tick has qualified.
- **Basic scan.** SHOW_TICKS=2, BLANK_TICKS=1, `tick`=1 constant, `value`=16'h1234, `digit_en`=F, `dp_in`=0. Release reset ->
  - first edge: `an`=E, `seg`=19, for 2 cycles;
  - then 1 cycle all-off;
  - then `an`=D `seg`=30, `an`=B `seg`=24, `an`=7 `seg`=79, each with the same 2-on/1-off pattern;
  - period is 12 cycles.
- **Mid-frame change.** Same setup; set `value`=16'hFFFF while digit 1 is shown -> digits 2 and 3 still show 24 and 79; the next frame shows 0E on all four digits.
- **Enables and decimal point.** `digit_en`=4'b0101, `dp_in`=4'b0001 -> `dp`=0 only during digit 0 SHOW; `an`=F during the digit 1 and digit 3 slots.
- **frame_done and sparse tick.**
  - No `frame_done` at the first wrap after reset.
  - Afterwards, exactly one pulse every 12 cycles with constant tick.
  - With `tick` pulsed every 4th cycle, outputs change only on tick cycles and the period is 48 cycles.
- **Reset mid-scan.** Assert `reset` for 1 cycle during digit 2 SHOW -> next edge all outputs off. After release, the scan restarts at digit 0 using the freshly latched `value`.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Each digit slot is SHOW_TICKS ticks of drive followed
// by BLANK_TICKS ticks of all-anodes-off to suppress ghosting. The displayed
// value, decimal points and enables are captured once per frame, on the edge
// that wraps back to digit 0, so a frame never mixes two values.
module seven_seg_scanner #(
  parameter int SHOW_TICKS  = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic {SHOW, BLANK} state_t;

  localparam logic [7:0] SHOW_LAST  = 8'(SHOW_TICKS - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_TICKS - 1);

  state_t      state_reg, state_next;
  logic [1:0]  d_reg, d_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] sh_val_reg, sh_val_next;
  logic [3:0]  sh_dp_reg, sh_dp_next;
  logic [3:0]  sh_en_reg, sh_en_next;
  logic        first_reg, first_next;

  logic [3:0]  an_next;
  logic [6:0]  seg_next;
  logic        dp_next;
  logic        fd_next;

  // Nibbles of the shadow value as it will be after this edge, so the digit
  // shown on the wrap edge already comes from the freshly latched value.
  logic [3:0]  nib [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = sh_val_next[4*gi +: 4];
    end
  endgenerate

  // Hex to active-low gfedcba segment pattern.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Next-state and next-output logic; everything holds on non-tick cycles
  // except frame_done, which is a single-cycle pulse.
  always_comb begin
    state_next  = state_reg;
    d_next      = d_reg;
    cnt_next    = cnt_reg;
    sh_val_next = sh_val_reg;
    sh_dp_next  = sh_dp_reg;
    sh_en_next  = sh_en_reg;
    first_next  = first_reg;
    fd_next     = 1'b0;

    if (tick) begin
      case (state_reg)
        SHOW: begin
          if (cnt_reg == SHOW_LAST) begin
            state_next = BLANK;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
        default: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = SHOW;
            cnt_next   = 8'd0;
            d_next     = d_reg + 2'd1;
            if (d_reg == 2'd3) begin
              sh_val_next = value;
              sh_dp_next  = dp_in;
              sh_en_next  = digit_en;
              first_next  = 1'b0;
              fd_next     = ~first_reg;
            end
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      endcase
    end

    an_next  = 4'hF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (state_next == SHOW && sh_en_next[d_next]) begin
      an_next  = ~(4'b0001 << d_next);
      seg_next = decode(nib[d_next]);
      dp_next  = ~sh_dp_next[d_next];
    end
  end

  // State, shadow and registered output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= BLANK;
      d_reg      <= 2'd3;
      cnt_reg    <= 8'd0;
      sh_val_reg <= 16'h0000;
      sh_dp_reg  <= 4'h0;
      sh_en_reg  <= 4'h0;
      first_reg  <= 1'b1;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_reg  <= state_next;
      d_reg      <= d_next;
      cnt_reg    <= cnt_next;
      sh_val_reg <= sh_val_next;
      sh_dp_reg  <= sh_dp_next;
      sh_en_reg  <= sh_en_next;
      first_reg  <= first_next;
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_done <= fd_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with SHOW_TICKS=2, BLANK_TICKS=1 (12-tick frame).
// Expected outputs come from a fixed vector table for the basic scan and from a
// small frame-position model for the remaining sequences; each expectation is
// queued when the cycle is driven and popped after the sampling edge.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scanner #(.SHOW_TICKS(2), .BLANK_TICKS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  typedef struct packed {
    logic tick;
    exp_t e;
  } vec_t;

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t sb_q [$];
  vec_t tbl [12];
  int   checks = 0;
  int   errors = 0;

  // Frame-position model: m_pos is -1 before the first tick after reset,
  // otherwise the tick position 0..11 within the frame (3 ticks per digit,
  // the third being blank).
  int          m_pos;
  logic        m_first;
  logic [15:0] m_val;
  logic [3:0]  m_en;
  logic [3:0]  m_dp;

  function automatic exp_t mk(input logic [3:0] a, input logic [6:0] s, input logic p, input logic f);
    exp_t e;
    e.an = a; e.seg = s; e.dp = p; e.fd = f;
    return e;
  endfunction

  function automatic exp_t model_out(input logic fd);
    int dg;
    logic [3:0] nb;
    exp_t e;
    e = mk(4'hF, 7'h7F, 1'b1, fd);
    if (m_pos >= 0 && (m_pos % 3) != 2) begin
      dg = m_pos / 3;
      if (m_en[dg]) begin
        nb   = m_val[4*dg +: 4];
        e.an = ~(4'b0001 << dg);
        e.seg = dec_tbl[nb];
        e.dp = ~m_dp[dg];
      end
    end
    return e;
  endfunction

  task automatic model_step(input logic rst, input logic t);
    logic fd;
    fd = 1'b0;
    if (rst) begin
      m_pos = -1; m_first = 1'b1; m_val = 16'h0; m_en = 4'h0; m_dp = 4'h0;
    end else if (t) begin
      m_pos = (m_pos + 1) % 12;
      if (m_pos == 0) begin
        fd = ~m_first;
        m_first = 1'b0;
        m_val = value; m_en = digit_en; m_dp = dp_in;
      end
    end
    sb_q.push_back(model_out(fd));
  endtask

  task automatic check_edge(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if ({an, seg, dp, frame_done} !== e) begin
      errors++;
      $display("FAIL %s #%0d: got an=%h seg=%h dp=%b fd=%b, expected an=%h seg=%h dp=%b fd=%b",
               name, checks, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
    end else begin
      $display("ok   %s #%0d: an=%h seg=%h dp=%b fd=%b", name, checks, an, seg, dp, frame_done);
    end
  endtask

  task automatic cycle(input logic rst, input logic t, input string name);
    reset = rst;
    tick  = t;
    model_step(rst, t);
    check_edge(name);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1;
    value = 16'h1234; digit_en = 4'hF; dp_in = 4'h0;

    tbl[0]  = '{1'b1, mk(4'hE, 7'h19, 1'b1, 1'b0)};
    tbl[1]  = '{1'b1, mk(4'hE, 7'h19, 1'b1, 1'b0)};
    tbl[2]  = '{1'b1, mk(4'hF, 7'h7F, 1'b1, 1'b0)};
    tbl[3]  = '{1'b1, mk(4'hD, 7'h30, 1'b1, 1'b0)};
    tbl[4]  = '{1'b1, mk(4'hD, 7'h30, 1'b1, 1'b0)};
    tbl[5]  = '{1'b1, mk(4'hF, 7'h7F, 1'b1, 1'b0)};
    tbl[6]  = '{1'b1, mk(4'hB, 7'h24, 1'b1, 1'b0)};
    tbl[7]  = '{1'b1, mk(4'hB, 7'h24, 1'b1, 1'b0)};
    tbl[8]  = '{1'b1, mk(4'hF, 7'h7F, 1'b1, 1'b0)};
    tbl[9]  = '{1'b1, mk(4'h7, 7'h79, 1'b1, 1'b0)};
    tbl[10] = '{1'b1, mk(4'h7, 7'h79, 1'b1, 1'b0)};
    tbl[11] = '{1'b1, mk(4'hF, 7'h7F, 1'b1, 1'b0)};

    // Reset held with tick active, then one idle cycle after release.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, "reset");
    cycle(1'b0, 1'b0, "post_rst");

    // Basic scan from the vector table, two frames; the second wrap pulses frame_done.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 12; i++) begin
        exp_t e;
        reset = 1'b0;
        tick  = tbl[i].tick;
        e = tbl[i].e;
        e.fd = (pass == 1 && i == 0);
        sb_q.push_back(e);
        check_edge("basic");
      end
    end

    // Mid-frame value change while digit 1 is shown.
    cycle(1'b1, 1'b1, "mid_rst");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, "midframe");
    value = 16'hFFFF;
    for (int i = 0; i < 19; i++) cycle(1'b0, 1'b1, "midframe");

    // Digit enables and decimal point.
    value = 16'h1234; digit_en = 4'b0101; dp_in = 4'b0001;
    cycle(1'b1, 1'b1, "en_rst");
    for (int i = 0; i < 24; i++) cycle(1'b0, 1'b1, "enable");

    // Sparse tick, every 4th cycle; 48-cycle frame.
    value = 16'h0C5A; digit_en = 4'hF; dp_in = 4'b1010;
    cycle(1'b1, 1'b1, "sp_rst");
    for (int k = 0; k < 104; k++) cycle(1'b0, (k % 4) == 0, "sparse");

    // Reset during digit 2 SHOW, then restart with a new value.
    value = 16'h1234; dp_in = 4'h0;
    cycle(1'b1, 1'b1, "mr_rst");
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, "pre_mr");
    value = 16'hABCD;
    cycle(1'b1, 1'b1, "midreset");
    for (int i = 0; i < 26; i++) cycle(1'b0, 1'b1, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
